// File: rtl/app_axis_pkg.sv
// Shared types and helpers for the AXI-Stream frame FIFO ingress stage.
package app_axis_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } frame_state_t;

   // One FIFO entry is {tdata, tstrb, tlast, tuser}.
   function automatic int entry_width(input int data_width, input int strb_width);
      return data_width + strb_width + 2;
   endfunction

   function automatic logic [8:0] popcount(input logic [255:0] v);
      logic [8:0] n;
      n = 9'd0;
      for (int i = 0; i < 256; i++) begin
         n = n + {8'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/app_axis_sync_fifo.sv
// Synchronous FIFO with occupancy level; read data comes straight from the head entry.
module app_axis_sync_fifo #(
   parameter int WIDTH = 38,
   parameter int DEPTH = 16
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_wr_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_rd_data,
   output logic [$clog2(DEPTH):0] o_level,
   output logic                   o_full,
   output logic                   o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_push && (r_level != (AW+1)'(DEPTH));
   assign w_pop  = i_pop && (r_level != '0);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_level   = r_level;
   assign o_full    = (r_level == (AW+1)'(DEPTH));
   assign o_empty   = (r_level == '0);

endmodule

// File: rtl/app_axis_frame_fifo.sv
// AXI-Stream frame FIFO with SOF/TLAST checking, optional whole-frame drop and statistics.
// Statistics counters exist only when APP_AXIS_FRAME_FIFO_STATS_EN is defined.
module app_axis_frame_fifo
   import app_axis_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH/8,
   parameter int DEPTH      = 16,
   parameter int DROP_MODE  = 0,
   parameter int CNT_WIDTH  = 32
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic [STRB_WIDTH-1:0]  s_axis_tstrb,
   input  logic                   s_axis_tlast,
   input  logic                   s_axis_tuser,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   output logic [DATA_WIDTH-1:0]  m_axis_tdata,
   output logic [STRB_WIDTH-1:0]  m_axis_tstrb,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tuser,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   input  logic                   clear_stats,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   fifo_full,
   output logic                   fifo_empty,
   output logic [CNT_WIDTH-1:0]   frame_cnt,
   output logic [CNT_WIDTH-1:0]   byte_cnt,
   output logic [CNT_WIDTH-1:0]   drop_cnt,
   output logic [CNT_WIDTH-1:0]   err_cnt
);
   localparam int EW = entry_width(DATA_WIDTH, STRB_WIDTH);

   frame_state_t  r_state;
   logic          w_full;
   logic          w_empty;
   logic          w_ready;
   logic          w_accept;
   logic          w_drop_now;
   logic          w_write;
   logic [EW-1:0] w_rd_entry;

   // An admitted frame is backpressured; only a new frame may be dropped.
   always_comb begin
      if ((DROP_MODE != 0) && (r_state != ST_PASS)) begin
         w_ready = 1'b1;
      end else begin
         w_ready = !w_full;
      end
   end

   assign w_accept   = s_axis_tvalid && w_ready;
   assign w_drop_now = (DROP_MODE != 0) && (r_state == ST_IDLE) && w_full;
   assign w_write    = w_accept && (r_state != ST_DROP) && !w_drop_now;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else if (w_accept) begin
         case (r_state)
            ST_IDLE:          if (!s_axis_tlast) r_state <= w_drop_now ? ST_DROP : ST_PASS;
            ST_PASS, ST_DROP: if (s_axis_tlast) r_state <= ST_IDLE;
            default:          r_state <= ST_IDLE;
         endcase
      end
   end

   app_axis_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_write),
      .i_wr_data ({s_axis_tdata, s_axis_tstrb, s_axis_tlast, s_axis_tuser}),
      .i_pop     (m_axis_tready),
      .o_rd_data (w_rd_entry),
      .o_level   (fifo_level),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   assign s_axis_tready = w_ready;
   assign fifo_full     = w_full;
   assign fifo_empty    = w_empty;
   assign m_axis_tvalid = !w_empty;
   assign m_axis_tdata  = w_empty ? '0 : w_rd_entry[EW-1 -: DATA_WIDTH];
   assign m_axis_tstrb  = w_empty ? '0 : w_rd_entry[STRB_WIDTH+1:2];
   assign m_axis_tlast  = w_empty ? 1'b0 : w_rd_entry[1];
   assign m_axis_tuser  = w_empty ? 1'b0 : w_rd_entry[0];

`ifdef APP_AXIS_FRAME_FIFO_STATS_EN
   logic [CNT_WIDTH-1:0] r_frame_cnt;
   logic [CNT_WIDTH-1:0] r_byte_cnt;
   logic [CNT_WIDTH-1:0] r_drop_cnt;
   logic [CNT_WIDTH-1:0] r_err_cnt;
   logic [CNT_WIDTH:0]   w_byte_sum;
   logic                 w_err;

   assign w_err      = w_accept && ((r_state == ST_IDLE) ? !s_axis_tuser : s_axis_tuser);
   assign w_byte_sum = {1'b0, r_byte_cnt} + (CNT_WIDTH+1)'(popcount(256'(s_axis_tstrb)));

   // Saturating counters; clear_stats wins over any same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_cnt <= '0;
         r_byte_cnt  <= '0;
         r_drop_cnt  <= '0;
         r_err_cnt   <= '0;
      end else if (clear_stats) begin
         r_frame_cnt <= '0;
         r_byte_cnt  <= '0;
         r_drop_cnt  <= '0;
         r_err_cnt   <= '0;
      end else begin
         if (w_write && s_axis_tlast && !(&r_frame_cnt)) r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
         if (w_write) r_byte_cnt <= w_byte_sum[CNT_WIDTH] ? '1 : w_byte_sum[CNT_WIDTH-1:0];
         if (w_accept && w_drop_now && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
         if (w_err && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
      end
   end

   assign frame_cnt = r_frame_cnt;
   assign byte_cnt  = r_byte_cnt;
   assign drop_cnt  = r_drop_cnt;
   assign err_cnt   = r_err_cnt;
`else
   assign frame_cnt = '0;
   assign byte_cnt  = '0;
   assign drop_cnt  = '0;
   assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_app_axis_frame_fifo.sv
// Directed bench: instance a is in backpressure mode, instance b in drop mode.
module tb_app_axis_frame_fifo;

`ifdef APP_AXIS_FRAME_FIFO_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] a_tdata = 32'd0, b_tdata = 32'd0;
   logic [3:0]  a_tstrb = 4'd0,  b_tstrb = 4'd0;
   logic        a_tlast = 1'b0, a_tuser = 1'b0, a_tvalid = 1'b0, a_s_tready;
   logic        b_tlast = 1'b0, b_tuser = 1'b0, b_tvalid = 1'b0, b_s_tready;
   logic [31:0] a_m_tdata, b_m_tdata;
   logic [3:0]  a_m_tstrb, b_m_tstrb;
   logic        a_m_tlast, a_m_tuser, a_m_tvalid, a_m_tready = 1'b0, a_clear = 1'b0;
   logic        b_m_tlast, b_m_tuser, b_m_tvalid, b_m_tready = 1'b0, b_clear = 1'b0;
   logic [4:0]  a_level, b_level;
   logic        a_full, a_empty, b_full, b_empty;
   logic [31:0] a_frame, a_byte, a_drop, a_err, b_frame, b_byte, b_drop, b_err;

   int total = 0;
   int bad   = 0;

   app_axis_frame_fifo #(.DATA_WIDTH(32), .DEPTH(16), .DROP_MODE(0), .CNT_WIDTH(32)) u_a (
      .clk(clk), .rst(rst),
      .s_axis_tdata(a_tdata), .s_axis_tstrb(a_tstrb), .s_axis_tlast(a_tlast),
      .s_axis_tuser(a_tuser), .s_axis_tvalid(a_tvalid), .s_axis_tready(a_s_tready),
      .m_axis_tdata(a_m_tdata), .m_axis_tstrb(a_m_tstrb), .m_axis_tlast(a_m_tlast),
      .m_axis_tuser(a_m_tuser), .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready),
      .clear_stats(a_clear), .fifo_level(a_level), .fifo_full(a_full), .fifo_empty(a_empty),
      .frame_cnt(a_frame), .byte_cnt(a_byte), .drop_cnt(a_drop), .err_cnt(a_err)
   );

   app_axis_frame_fifo #(.DATA_WIDTH(32), .DEPTH(16), .DROP_MODE(1), .CNT_WIDTH(32)) u_b (
      .clk(clk), .rst(rst),
      .s_axis_tdata(b_tdata), .s_axis_tstrb(b_tstrb), .s_axis_tlast(b_tlast),
      .s_axis_tuser(b_tuser), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_s_tready),
      .m_axis_tdata(b_m_tdata), .m_axis_tstrb(b_m_tstrb), .m_axis_tlast(b_m_tlast),
      .m_axis_tuser(b_m_tuser), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
      .clear_stats(b_clear), .fifo_level(b_level), .fifo_full(b_full), .fifo_empty(b_empty),
      .frame_cnt(b_frame), .byte_cnt(b_byte), .drop_cnt(b_drop), .err_cnt(b_err)
   );

   function automatic logic [31:0] e(input logic [31:0] v);
      return STATS ? v : 32'd0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one beat on instance a; it must be accepted at the next edge.
   task automatic beat_a(input logic [31:0] d, input logic [3:0] s, input logic u, input logic l);
      a_tdata = d; a_tstrb = s; a_tuser = u; a_tlast = l; a_tvalid = 1'b1;
      chk("a_ready", {63'd0, a_s_tready}, 64'd1);
      @(posedge clk); #1;
      a_tvalid = 1'b0;
   endtask

   task automatic beat_b(input logic [31:0] d, input logic [3:0] s, input logic u, input logic l);
      b_tdata = d; b_tstrb = s; b_tuser = u; b_tlast = l; b_tvalid = 1'b1;
      chk("b_ready", {63'd0, b_s_tready}, 64'd1);
      @(posedge clk); #1;
      b_tvalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int in_idx;
      int out_idx;
      bit acc;
      bit pop;

      // Reset
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_mvalid", {63'd0, a_m_tvalid}, 64'd0);
      chk("rst_mdata",  {32'd0, a_m_tdata}, 64'd0);
      chk("rst_level",  {59'd0, a_level}, 64'd0);
      chk("rst_empty",  {63'd0, a_empty}, 64'd1);
      chk("rst_full",   {63'd0, a_full}, 64'd0);
      chk("rst_frame",  {32'd0, a_frame}, 64'd0);
      chk("rst_byte",   {32'd0, a_byte}, 64'd0);
      chk("rst_err",    {32'd0, a_err}, 64'd0);
      chk("rst_drop",   {32'd0, b_drop}, 64'd0);
      chk("rst_ready_a", {63'd0, a_s_tready}, 64'd1);
      chk("rst_ready_b", {63'd0, b_s_tready}, 64'd1);

      // Basic frame, each beat visible one cycle after accept
      a_m_tready = 1'b1;
      beat_a(32'hA5A5A5A5, 4'hF, 1'b1, 1'b0);
      chk("basic_d0", {32'd0, a_m_tdata}, 64'hA5A5A5A5);
      chk("basic_sof", {63'd0, a_m_tuser}, 64'd1);
      beat_a(32'hB5B5B5B5, 4'hF, 1'b0, 1'b0);
      chk("basic_d1", {32'd0, a_m_tdata}, 64'hB5B5B5B5);
      beat_a(32'hC5C5C5C5, 4'hF, 1'b0, 1'b1);
      chk("basic_d2", {32'd0, a_m_tdata}, 64'hC5C5C5C5);
      chk("basic_last", {63'd0, a_m_tlast}, 64'd1);
      @(posedge clk); #1;
      chk("basic_empty", {63'd0, a_empty}, 64'd1);
      chk("basic_frame", {32'd0, a_frame}, {32'd0, e(32'd1)});
      chk("basic_byte",  {32'd0, a_byte}, {32'd0, e(32'd12)});
      chk("basic_err",   {32'd0, a_err}, 64'd0);

      // Backpressure: 20 beats into a 16-deep FIFO
      a_m_tready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         beat_a(32'h10000000 + i, 4'hF, (i == 0), 1'b0);
      end
      chk("bp_level", {59'd0, a_level}, 64'd16);
      chk("bp_full",  {63'd0, a_full}, 64'd1);
      chk("bp_ready", {63'd0, a_s_tready}, 64'd0);
      a_tdata = 32'h10000010; a_tstrb = 4'hF; a_tuser = 1'b0; a_tlast = 1'b0; a_tvalid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("bp_hold_level", {59'd0, a_level}, 64'd16);
      chk("bp_hold_data",  {32'd0, a_m_tdata}, 64'h10000000);
      in_idx = 16;
      out_idx = 0;
      a_m_tready = 1'b1;
      for (int c = 0; c < 100 && out_idx < 20; c++) begin
         acc = a_tvalid && a_s_tready;
         pop = a_m_tvalid;
         if (pop) begin
            chk("bp_order", {32'd0, a_m_tdata}, 64'h10000000 + 64'(out_idx));
            out_idx++;
         end
         @(posedge clk); #1;
         if (acc) begin
            in_idx++;
            if (in_idx < 20) begin
               a_tdata = 32'h10000000 + 32'(in_idx);
               a_tlast = (in_idx == 19);
            end else begin
               a_tvalid = 1'b0;
               a_tlast  = 1'b0;
            end
         end
      end
      chk("bp_count", 64'(out_idx), 64'd20);
      chk("bp_drained", {59'd0, a_level}, 64'd0);
      chk("bp_frame", {32'd0, a_frame}, {32'd0, e(32'd2)});
      chk("bp_byte",  {32'd0, a_byte}, {32'd0, e(32'd92)});

      // Errors and strobe
      beat_a(32'h11111111, 4'hF, 1'b0, 1'b0);
      chk("err_d0", {32'd0, a_m_tdata}, 64'h11111111);
      chk("err_cnt1", {32'd0, a_err}, {32'd0, e(32'd1)});
      beat_a(32'h22222222, 4'hF, 1'b1, 1'b0);
      chk("err_d1", {32'd0, a_m_tdata}, 64'h22222222);
      beat_a(32'h33333333, 4'h3, 1'b0, 1'b1);
      chk("err_d2", {32'd0, a_m_tdata}, 64'h33333333);
      chk("err_strb", {60'd0, a_m_tstrb}, 64'h3);
      chk("err_cnt2", {32'd0, a_err}, {32'd0, e(32'd2)});
      chk("err_byte", {32'd0, a_byte}, {32'd0, e(32'd102)});
      chk("err_frame", {32'd0, a_frame}, {32'd0, e(32'd3)});
      @(posedge clk); #1;

      // Drop mode: full FIFO drops a whole new frame
      b_m_tready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         beat_b(32'h20000000 + i, 4'hF, (i == 0), (i == 15));
      end
      chk("drop_fill_level", {59'd0, b_level}, 64'd16);
      chk("drop_fill_full",  {63'd0, b_full}, 64'd1);
      chk("drop_fill_ready", {63'd0, b_s_tready}, 64'd1);
      beat_b(32'hDEAD0001, 4'hF, 1'b1, 1'b0);
      chk("drop_lvl1", {59'd0, b_level}, 64'd16);
      beat_b(32'hDEAD0002, 4'hF, 1'b0, 1'b1);
      chk("drop_lvl2", {59'd0, b_level}, 64'd16);
      chk("drop_cnt",   {32'd0, b_drop}, {32'd0, e(32'd1)});
      chk("drop_frame", {32'd0, b_frame}, {32'd0, e(32'd1)});
      chk("drop_err",   {32'd0, b_err}, 64'd0);
      b_m_tready = 1'b1;
      out_idx = 0;
      for (int c = 0; c < 20; c++) begin
         if (b_m_tvalid) begin
            chk("drop_drain", {32'd0, b_m_tdata}, 64'h20000000 + 64'(out_idx));
            out_idx++;
         end
         @(posedge clk); #1;
      end
      chk("drop_count", 64'(out_idx), 64'd16);
      chk("drop_empty", {63'd0, b_empty}, 64'd1);
      beat_b(32'hD00DF00D, 4'hF, 1'b1, 1'b1);
      chk("drop_fwd", {32'd0, b_m_tdata}, 64'hD00DF00D);
      chk("drop_fwd_sof", {63'd0, b_m_tuser}, 64'd1);
      chk("drop_fwd_last", {63'd0, b_m_tlast}, 64'd1);
      chk("drop_fwd_strb", {60'd0, b_m_tstrb}, 64'hF);
      chk("drop_frame2", {32'd0, b_frame}, {32'd0, e(32'd2)});
      chk("drop_byte", {32'd0, b_byte}, {32'd0, e(32'd68)});

      // Reset mid-frame, then clear_stats against a tlast accept
      a_m_tready = 1'b0;
      beat_a(32'h44444444, 4'hF, 1'b1, 1'b0);
      beat_a(32'h55555555, 4'hF, 1'b0, 1'b0);
      chk("mid_level", {59'd0, a_level}, 64'd2);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {63'd0, a_m_tvalid}, 64'd0);
      chk("mid_rst_data",  {32'd0, a_m_tdata}, 64'd0);
      chk("mid_rst_level", {59'd0, a_level}, 64'd0);
      chk("mid_rst_empty", {63'd0, a_empty}, 64'd1);
      chk("mid_rst_frame", {32'd0, a_frame}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      beat_a(32'h66666666, 4'hF, 1'b1, 1'b0);
      chk("post_rst_data", {32'd0, a_m_tdata}, 64'h66666666);
      chk("post_rst_err",  {32'd0, a_err}, 64'd0);
      chk("post_rst_byte", {32'd0, a_byte}, {32'd0, e(32'd4)});
      a_clear = 1'b1;
      beat_a(32'h77777777, 4'hF, 1'b0, 1'b1);
      a_clear = 1'b0;
      chk("clr_frame", {32'd0, a_frame}, 64'd0);
      chk("clr_byte",  {32'd0, a_byte}, 64'd0);
      chk("clr_level", {59'd0, a_level}, 64'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
